// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, NREAD
// read ports with per-port busy flags, issue/flush scoreboard controls and
// the full busy vector. The master drives requests, the slave (the register
// file) answers with read data and scoreboard state.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) ();

  localparam int NREGS = 2 ** AW;

  // Write port A
  logic                  we_a;
  logic [AW-1:0]         wa_a;
  logic [XLEN-1:0]       wd_a;

  // Write port B (wins over A on an address collision)
  logic                  we_b;
  logic [AW-1:0]         wa_b;
  logic [XLEN-1:0]       wd_b;

  // Read ports, packed: port i occupies [i*AW +: AW] / [i*XLEN +: XLEN]
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rbusy;

  // Scoreboard controls and state
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  flush;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output we_a, wa_a, wd_a,
    output we_b, wa_b, wd_b,
    output raddr,
    output issue_valid, issue_rd, flush,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we_a, wa_a, wd_a,
    input  we_b, wa_b, wd_b,
    input  raddr,
    input  issue_valid, issue_rd, flush,
    output rdata, rbusy, busy_vec
  );

endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with a per-register busy
// scoreboard. Register 0 is hard-wired to zero. Two write ports (B has
// priority over A on the same address), NREAD combinational read ports with
// optional same-cycle write forwarding, and an issue/complete/flush busy
// tracker used by decode for hazard detection.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           reset,
  regfile_mp_if.slave   bus
);

  localparam int NREGS = 2 ** AW;

  // Architectural state. Entry 0 exists only to keep indexing simple; it is
  // reset to zero and never written, and reads of address 0 are forced to 0.
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Effective write strobes after discarding x0 writes and resolving the
  // A/B collision in favour of B.
  logic wr_a_ok;
  logic wr_b_ok;

  // Per-register scoreboard events for this cycle.
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_next;

  // Packed read results collected from every port.
  logic [NREAD*XLEN-1:0] rdata_int;
  logic [NREAD-1:0]      rbusy_int;

  // Qualify the two write ports.
  assign wr_b_ok = bus.we_b && (bus.wa_b != '0);
  assign wr_a_ok = bus.we_a && (bus.wa_a != '0) &&
                   !(bus.we_b && (bus.wa_b == bus.wa_a));

  // Register array update; reset clears every entry asynchronously.
  // NOTE: the data array is reset on purpose: software relies on every
  // register reading 0 after reset, so this is not a plain RAM that can be
  // left uninitialised. Sequential state always uses non-blocking '<='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (wr_a_ok) begin
        regs[bus.wa_a] <= bus.wd_a;
      end
      if (wr_b_ok) begin
        regs[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  // Decode issue and write-completion events into per-register vectors.
  // NOTE: every signal assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned (which would infer a latch); blocking
  // '=' is correct here because this is combinational logic.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.issue_valid) begin
      set_vec[bus.issue_rd] = 1'b1;
    end
    if (bus.we_a) begin
      clr_vec[bus.wa_a] = 1'b1;
    end
    if (bus.we_b) begin
      clr_vec[bus.wa_b] = 1'b1;
    end
    // x0 never becomes busy.
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
  end

  // Next busy state: flush beats everything, a new producer beats a
  // completing write, otherwise a completing write clears the bit.
  always_comb begin
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      busy_next = (busy & ~clr_vec) | set_vec;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Independent combinational read ports.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = bus.raddr[i*AW +: AW];

    // Stored value with optional forwarding of this cycle's write data;
    // B is checked first to match the collision rule.
    always_comb begin
      rd = '0;
      if (ra != '0) begin
        rd = regs[ra];
        if (BYPASS != 0) begin
          if (bus.we_b && (bus.wa_b == ra)) begin
            rd = bus.wd_b;
          end else if (bus.we_a && (bus.wa_a == ra)) begin
            rd = bus.wd_a;
          end
        end
      end
    end

    assign rdata_int[i*XLEN +: XLEN] = rd;
    // Busy flag is registered state only, never forwarded.
    assign rbusy_int[i] = busy[ra];
  end

  assign bus.rdata    = rdata_int;
  assign bus.rbusy    = rbusy_int;
  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances run side by side on the same
// stimulus, one with forwarding (BYPASS=1) and one without (BYPASS=0).
// Stimulus pushes hand-computed expectations into a scoreboard queue and
// toggles a strobe; a separate monitor pops and compares against the DUTs.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;
  localparam int NREGS = 2 ** AW;

  typedef enum int { K_RDATA, K_RBUSY, K_BVEC } kind_t;

  typedef struct {
    string       name;
    int          dut;   // 1 = BYPASS=1 instance, 0 = BYPASS=0 instance
    kind_t       kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  logic clk;
  logic reset;

  logic             we_a, we_b, issue_valid, flush;
  logic [AW-1:0]    wa_a, wa_b, issue_rd;
  logic [XLEN-1:0]  wd_a, wd_b;
  logic [NREAD*AW-1:0] raddr;

  exp_t sb[$];
  logic strobe;
  int   total;
  int   bad;

  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) bus1 ();
  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) bus0 ();

  assign bus1.we_a = we_a;  assign bus0.we_a = we_a;
  assign bus1.wa_a = wa_a;  assign bus0.wa_a = wa_a;
  assign bus1.wd_a = wd_a;  assign bus0.wd_a = wd_a;
  assign bus1.we_b = we_b;  assign bus0.we_b = we_b;
  assign bus1.wa_b = wa_b;  assign bus0.wa_b = wa_b;
  assign bus1.wd_b = wd_b;  assign bus0.wd_b = wd_b;
  assign bus1.raddr = raddr;  assign bus0.raddr = raddr;
  assign bus1.issue_valid = issue_valid;  assign bus0.issue_valid = issue_valid;
  assign bus1.issue_rd = issue_rd;  assign bus0.issue_rd = issue_rd;
  assign bus1.flush = flush;  assign bus0.flush = flush;

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .BYPASS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .BYPASS(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] get_act(input int dut, input kind_t kind, input int idx);
    logic [63:0] v;
    v = '0;
    case (kind)
      K_RDATA: v = 64'(dut == 1 ? bus1.rdata[idx*XLEN +: XLEN] : bus0.rdata[idx*XLEN +: XLEN]);
      K_RBUSY: v = 64'(dut == 1 ? bus1.rbusy[idx] : bus0.rbusy[idx]);
      K_BVEC:  v = 64'(dut == 1 ? bus1.busy_vec : bus0.busy_vec);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Monitor: whenever the stimulus presents a settled output set, drain the
  // scoreboard and compare every pending expectation.
  always @(strobe) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e   = sb.pop_front();
      act = get_act(e.dut, e.kind, e.idx);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s (dut bypass=%0d idx=%0d): got %h expected %h",
                 e.name, e.dut, e.idx, act, e.exp);
      end
    end
  end

  task automatic push(input string nm, input int dut, input kind_t k, input int idx,
                      input logic [63:0] v);
    exp_t e;
    e.name = nm; e.dut = dut; e.kind = k; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input string nm, input int port, input logic [31:0] v1,
                        input logic [31:0] v0);
    push(nm, 1, K_RDATA, port, 64'(v1));
    push(nm, 0, K_RDATA, port, 64'(v0));
  endtask

  task automatic exp_rbusy(input string nm, input int port, input logic v);
    push(nm, 1, K_RBUSY, port, 64'(v));
    push(nm, 0, K_RBUSY, port, 64'(v));
  endtask

  task automatic exp_bvec(input string nm, input logic [NREGS-1:0] v);
    push(nm, 1, K_BVEC, 0, 64'(v));
    push(nm, 0, K_BVEC, 0, 64'(v));
  endtask

  task automatic fire();
    strobe = ~strobe;
    #1;
  endtask

  task automatic clear_in();
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic set_raddr(input int p0, input int p1);
    raddr = {AW'(p1), AW'(p0)};
  endtask

  initial begin
    total = 0;
    bad = 0;
    strobe = 1'b0;
    reset = 1'b1;
    clear_in();
    set_raddr(5, 0);

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    exp_rd("reset_rd0", 0, 32'h0, 32'h0);
    exp_rd("reset_rd1", 1, 32'h0, 32'h0);
    exp_bvec("reset_bvec", '0);
    fire();
    @(negedge clk); reset = 1'b0;

    // Write x5 and issue x12, then reset mid-run between clock edges
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 5'd12;
    set_raddr(5, 12);
    #1;
    exp_rd("x5_bypass", 0, 32'hDEADBEEF, 32'h0);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_rd("x5_stored", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_bvec("x12_busy", NREGS'(1) << 12);
    exp_rbusy("x12_rbusy", 1, 1'b1);
    fire();
    #1; reset = 1'b1;
    #1;
    exp_rd("async_rst_x5", 0, 32'h0, 32'h0);
    exp_bvec("async_rst_bvec", '0);
    exp_rbusy("async_rst_rbusy", 1, 1'b0);
    fire();
    @(negedge clk); reset = 1'b0;

    // x3 write, x0 hard zero
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h11;
    @(negedge clk); clear_in(); set_raddr(3, 0);
    #1;
    exp_rd("x3_read", 0, 32'h11, 32'h11);
    exp_rd("x0_read", 1, 32'h0, 32'h0);
    fire();
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFF;
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hEE;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    exp_rd("x0_no_bypass", 1, 32'h0, 32'h0);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_rd("x0_after_write", 1, 32'h0, 32'h0);
    exp_bvec("x0_never_busy", '0);
    fire();

    // Collision on x7: B wins, both in forwarding and in storage
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h77;
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hAAAA;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'hBBBB;
    set_raddr(7, 0);
    #1;
    exp_rd("x7_collide_now", 0, 32'hBBBB, 32'h77);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_rd("x7_collide_next", 0, 32'hBBBB, 32'hBBBB);
    fire();

    // Distinct addresses on A and B, each forwarded on its own port
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd11; wd_a = 32'h1234;
    we_b = 1'b1; wa_b = 5'd13; wd_b = 32'h5678;
    set_raddr(11, 13);
    #1;
    exp_rd("x11_fwd_a", 0, 32'h1234, 32'h0);
    exp_rd("x13_fwd_b", 1, 32'h5678, 32'h0);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_rd("x11_stored", 0, 32'h1234, 32'h1234);
    exp_rd("x13_stored", 1, 32'h5678, 32'h5678);
    fire();

    // Issue x9, complete with a port-B write
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd9; set_raddr(0, 9);
    #1;
    exp_bvec("x9_not_yet", '0);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_bvec("x9_busy", NREGS'(1) << 9);
    exp_rbusy("x9_rbusy", 1, 1'b1);
    fire();
    @(negedge clk);
    we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h42;
    #1;
    exp_rbusy("x9_rbusy_no_fwd", 1, 1'b1);
    exp_rd("x9_fwd", 1, 32'h42, 32'h0);
    fire();
    @(negedge clk); clear_in();
    #1;
    exp_bvec("x9_cleared", '0);
    exp_rbusy("x9_rbusy_clr", 1, 1'b0);
    exp_rd("x9_stored", 1, 32'h42, 32'h42);
    fire();

    // Issue and write the same busy register: set wins, data lands
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd4;
    we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h4444;
    #1;
    exp_bvec("x4_busy_before", NREGS'(1) << 4);
    fire();
    @(negedge clk); clear_in(); set_raddr(4, 0);
    #1;
    exp_bvec("x4_set_wins", NREGS'(1) << 4);
    exp_rd("x4_data", 0, 32'h4444, 32'h4444);
    fire();

    // Several producers, then flush together with an issue
    @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd2;
    @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd6;
    @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd8;
    @(negedge clk); clear_in();
    #1;
    exp_bvec("multi_busy", NREGS'(32'h154));
    fire();
    @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd10;
    @(negedge clk); clear_in(); set_raddr(3, 7);
    #1;
    exp_bvec("flush_clears", '0);
    exp_rd("flush_keeps_x3", 0, 32'h11, 32'h11);
    exp_rd("flush_keeps_x7", 1, 32'hBBBB, 32'hBBBB);
    fire();

    @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file.
- Successor to the single-write, two-read register file used by the core pipeline.
- Adds configurable width, depth and read-port count, plus a second write port with defined priority and optional write-to-read bypass.
- Adds a per-register busy scoreboard for hazard detection in the decode stage.

Parameters:
- XLEN, 32, data width of each register in bits.
- AW, 5, register address width; register count NREGS = 2**AW.
- NREAD, 2, number of read ports.
- BYPASS, 1, 1 = a read returns same-cycle write data for a matching address; 0 = a read returns stored state only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and all busy bits.
- we_a  in  1  write enable, port A.
- wa_a  in  AW  write address, port A.
- wd_a  in  XLEN  write data, port A.
- we_b  in  1  write enable, port B.
- wa_b  in  AW  write address, port B.
- wd_b  in  XLEN  write data, port B.
- raddr  in  NREAD*AW  read addresses; port i = bits [i*AW +: AW].
- rdata  out  NREAD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rbusy  out  NREAD  busy flag of the register addressed by each read port.
- issue_valid  in  1  marks register issue_rd as having a pending producer.
- issue_rd  in  AW  destination register being issued.
- flush  in  1  synchronous clear of all busy bits; register contents are kept.
- busy_vec  out  NREGS  full scoreboard, bit r = register r busy.

Behaviour:
- Reset: asserting reset immediately, without waiting for a clock edge, sets all registers to 0 and all busy bits to 0. This also applies when reset arrives mid-operation.
  - During reset, rdata = 0 on every port (unless BYPASS forwards in-flight write data), rbusy = 0, busy_vec = 0.
  - Writes, issues and flush are ignored while reset is high.
- Register 0 is hard zero:
  - Writes to address 0 on either port are discarded.
  - A read of address 0 always returns 0, including under bypass.
  - Busy bit 0 is never set; issue_rd = 0 is ignored.
- Reads are combinational, zero latency. Every read port is independent and any ports may share an address.
- Writes take effect at the rising clock edge; stored data becomes visible on the following cycle.
- Write collision: we_a and we_b both high with wa_a == wa_b != 0 -> port B's data is stored; port A's write is dropped.
- Bypass (BYPASS=1): for each read port i with raddr_i != 0:
  - If we_b and wa_b == raddr_i, then rdata_i = wd_b.
  - Else if we_a and wa_a == raddr_i, then rdata_i = wd_a.
  - Else rdata_i = stored value.
  - The priority matches the write-collision rule.
- BYPASS=0: rdata shows the old value until the cycle after the write.
- Scoreboard, per register r != 0, evaluated at each rising edge:
  - set = issue_valid and issue_rd == r.
  - clr = (we_a and wa_a == r) or (we_b and wa_b == r).
  - flush = 1 -> busy[r] <= 0, overriding both set and clr.
  - Else set = 1 -> busy[r] <= 1. When set and clr coincide, set wins: the new producer supersedes the completing write.
  - Else clr = 1 -> busy[r] <= 0.
  - Else busy[r] is held.
- rbusy_i = busy_vec[raddr_i]; reflects registered state only and is not bypassed.
- Wrap-around: none. All addresses are AW bits wide and always in range.
- A write to a non-busy register is legal and simply updates the register.

Test Plan:
- Assert reset mid-run after writing x5 = 0xDEADBEEF -> rdata for x5 reads 0 before the next clk edge; busy_vec = 0.
- Write A x3 = 0x11, then read x3 on port 0 and x0 on port 1 next cycle -> port 0 = 0x11, port 1 = 0. Then write x0 = 0xFF -> x0 still reads 0; busy_vec[0] = 0.
- Same cycle, A and B both write x7 (A = 0xAAAA, B = 0xBBBB), raddr0 = 7:
  - BYPASS=1 -> rdata0 = 0xBBBB in that cycle.
  - Next cycle -> stored value 0xBBBB.
  - BYPASS=0 -> old value in that cycle, 0xBBBB next cycle.
- Issue x9 -> busy_vec[9] = 1 next cycle and rbusy = 1 when x9 is read. Then write x9 = 0x42 -> busy clears the cycle after the write.
- Same cycle, issue x4 and write x4 (previously busy) -> busy[4] stays 1 and x4 = the written data.
- Issue x2, x6, x8 on successive cycles, then flush -> busy_vec = 0 next cycle; register contents unchanged. Also drive flush together with issue x10 -> busy[10] = 0.
